// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, reads a combinational imem and buffers {pc, op} in a
// small first-word-fall-through queue toward decode. A redirect flushes the queue.
module ifetch #(
  parameter int unsigned     AW       = 8,
  parameter int unsigned     DW       = 16,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] pc_o,
  input  logic [DW-1:0] op_i,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  output logic          out_valid,
  output logic [DW-1:0] out_op,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);

  logic [AW-1:0]   pc_q, pc_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [DW-1:0]   op_mem_q [DEPTH];
  logic [AW-1:0]   pc_mem_q [DEPTH];

  logic pop, push;

  assign pc_o      = pc_q;
  assign out_valid = (count_q != '0);
  assign out_op    = op_mem_q[head_q];
  assign out_pc    = pc_mem_q[head_q];

  assign pop  = out_valid & out_ready;
  assign push = ~redir_valid & ((count_q < Full) | pop);

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redir_valid) begin
      // Redirect wins: drop everything prefetched and restart at the target.
      pc_d    = redir_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + AW'(1);
        tail_d = (tail_q == LastPtr) ? '0 : tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = (head_q == LastPtr) ? '0 : head_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; out_* are don't-care while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      op_mem_q[tail_q] <= op_i;
      pc_mem_q[tail_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: imem is modelled as op = {~pc, pc}, checks sampled 1ns after
// each rising edge.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_o;
  logic [15:0] op_i;
  logic        redir_valid;
  logic [7:0]  redir_pc;
  logic        out_valid;
  logic [15:0] out_op;
  logic [7:0]  out_pc;
  logic        out_ready;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  assign op_i = {~pc_o, pc_o};

  ifetch #(
    .AW      (8),
    .DW      (16),
    .DEPTH   (2),
    .RESET_PC(8'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_o       (pc_o),
    .op_i       (op_i),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .out_valid  (out_valid),
    .out_op     (out_op),
    .out_pc     (out_pc),
    .out_ready  (out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic head(input string tag, input logic [7:0] pc);
    logic [15:0] op;
    op = {~pc, pc};
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".pc"}, 32'(out_pc), 32'(pc));
    chk({tag, ".op"}, 32'(out_op), 32'(op));
  endtask

  initial begin
    rst         = 1'b1;
    out_ready   = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = 8'd0;
    step();
    step();
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.pc_o", 32'(pc_o), 32'd0);

    // 1: streaming from reset
    rst = 1'b0;
    step();
    head("t1.h0", 8'd0);
    chk("t1.pc_o", 32'(pc_o), 32'd1);
    step(); head("t1.h1", 8'd1);
    step(); head("t1.h2", 8'd2);
    step(); head("t1.h3", 8'd3);

    // 2: fill with ready low, then drain in order
    rst = 1'b1; out_ready = 1'b0;
    step();
    chk("t2.rst.valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    step(); head("t2.f0", 8'd0); chk("t2.f0.pc_o", 32'(pc_o), 32'd1);
    step(); head("t2.f1", 8'd0); chk("t2.f1.pc_o", 32'(pc_o), 32'd2);
    step(); head("t2.full", 8'd0); chk("t2.full.pc_o", 32'(pc_o), 32'd2);
    out_ready = 1'b1;
    step(); head("t2.d1", 8'd1);
    step(); head("t2.d2", 8'd2);
    step(); head("t2.d3", 8'd3);

    // 3: redirect while full
    out_ready = 1'b0;
    step(); head("t3.fill", 8'd3); chk("t3.fill.pc_o", 32'(pc_o), 32'd5);
    step(); head("t3.hold", 8'd3); chk("t3.hold.pc_o", 32'(pc_o), 32'd5);
    redir_valid = 1'b1; redir_pc = 8'd20;
    step();
    chk("t3.redir.valid", 32'(out_valid), 32'd0);
    chk("t3.redir.pc_o", 32'(pc_o), 32'd20);
    redir_valid = 1'b0; out_ready = 1'b1;
    step(); head("t3.h20", 8'd20);
    step(); head("t3.h21", 8'd21);
    step(); head("t3.h22", 8'd22);

    // 4: redirect to FE, PC wraps
    redir_valid = 1'b1; redir_pc = 8'hFE;
    step();
    chk("t4.redir.valid", 32'(out_valid), 32'd0);
    chk("t4.redir.pc_o", 32'(pc_o), 32'hFE);
    redir_valid = 1'b0;
    step(); head("t4.hFE", 8'hFE);
    step(); head("t4.hFF", 8'hFF);
    step(); head("t4.h00", 8'h00);
    step(); head("t4.h01", 8'h01);

    // 5: redirect concurrent with a pop, then back-to-back redirects
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      head("t5.run", 8'(i));
    end
    redir_valid = 1'b1; redir_pc = 8'd40;
    step();
    chk("t5.redir.valid", 32'(out_valid), 32'd0);
    redir_valid = 1'b0;
    step(); head("t5.h40", 8'd40);
    redir_valid = 1'b1; redir_pc = 8'd9;
    step();
    chk("t5.b1.valid", 32'(out_valid), 32'd0);
    chk("t5.b1.pc_o", 32'(pc_o), 32'd9);
    redir_pc = 8'd26;
    step();
    chk("t5.b2.valid", 32'(out_valid), 32'd0);
    chk("t5.b2.pc_o", 32'(pc_o), 32'd26);
    redir_valid = 1'b0;
    step(); head("t5.h26", 8'd26);
    step(); head("t5.h27", 8'd27);

    // 6: reset mid-stream overrides a concurrent redirect
    rst = 1'b1; redir_valid = 1'b1; redir_pc = 8'd77;
    step();
    chk("t6.rst.valid", 32'(out_valid), 32'd0);
    chk("t6.rst.pc_o", 32'(pc_o), 32'd0);
    rst = 1'b0; redir_valid = 1'b0;
    step(); head("t6.h0", 8'd0);
    step(); head("t6.h1", 8'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
